mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl_if.sv | 30 +++
 rtl/mbist_march_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_ctrl_if.sv
// SRAM-side bus of the March C- MBIST controller.
// master: the BIST controller driving the SRAM; slave: the SRAM (or its model).
interface mbist_march_ctrl_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) ();

  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramin;
  logic              rwbar;   // 1 = read, 0 = write
  logic              cs;
  logic [DATA_W-1:0] ramout;  // valid the cycle after a read is issued

  modport master (
    output ramaddr,
    output ramin,
    output rwbar,
    output cs,
    input  ramout
  );

  modport slave (
    input  ramaddr,
    input  ramin,
    input  rwbar,
    input  cs,
    output ramout
  );

endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller for a synchronous single-port SRAM.
//   E0 up w0 | E1 up (r0,w1) | E2 up (r1,w0) | E3 down (r0,w1) | E4 down (r1,w0) | E5 up r0
// Each read takes RD (issue) + CMP (check ramout) at the same address; E1-E4 then write (WR).
// Optional build macro MBIST_FAIL_STOP_EN: end the test at the first read mismatch.
module mbist_march_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mbist_march_ctrl_if.master   ram,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [2:0]           fail_elem
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StCmp, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [2:0]        ElemLast = 3'd5;

  state_e            state_q;
  logic [2:0]        elem_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cs_q;
  logic              rwbar_q;
  logic [DATA_W-1:0] ramin_q;
  logic              busy_q;
  logic              done_q;
  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;

  logic              elem_down;
  logic              addr_last;
  logic [ADDR_W-1:0] addr_step;
  logic [2:0]        elem_next;
  logic              next_down;
  logic [DATA_W-1:0] rd_bg;
  logic [DATA_W-1:0] wr_bg;
  logic              mismatch;
  logic              stop_now;

  // Address walk, background selection and read comparison for the current element.
  always_comb begin
    elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    addr_last = elem_down ? (addr_q == '0) : (addr_q == AddrMax);
    addr_step = elem_down ? (addr_q - AddrOne) : (addr_q + AddrOne);
    elem_next = elem_q + 3'd1;
    next_down = (elem_next == 3'd3) || (elem_next == 3'd4);
    // Odd elements (E1, E3, E5) read zeros and E1/E3 write ones; even ones are the inverse.
    rd_bg     = {DATA_W{~elem_q[0]}};
    wr_bg     = {DATA_W{elem_q[0]}};
    mismatch  = (ram.ramout != rd_bg);
`ifdef MBIST_FAIL_STOP_EN
    stop_now  = mismatch;
`else
    stop_now  = 1'b0;
`endif
  end

  // Sequencer: state, address/element counters, registered SRAM controls and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      rwbar_q     <= 1'b1;
      ramin_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StWr;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            cs_q        <= 1'b1;
            rwbar_q     <= 1'b0;
            ramin_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
          end
        end
        StWr: begin
          if (!addr_last) begin
            addr_q <= addr_step;
            // E0 is write-only; later elements start each address with a read.
            if (elem_q != 3'd0) begin
              state_q <= StRd;
              rwbar_q <= 1'b1;
              ramin_q <= '0;
            end
          end else begin
            elem_q  <= elem_next;
            addr_q  <= next_down ? AddrMax : '0;
            state_q <= StRd;
            rwbar_q <= 1'b1;
            ramin_q <= '0;
          end
        end
        StRd: begin
          state_q <= StCmp;
        end
        StCmp: begin
          if (mismatch && !fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= addr_q;
            fail_elem_q <= elem_q;
          end
          if (stop_now || ((elem_q == ElemLast) && addr_last)) begin
            state_q <= StDone;
            cs_q    <= 1'b0;
            rwbar_q <= 1'b1;
            ramin_q <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (elem_q == ElemLast) begin
            addr_q  <= addr_step;
            state_q <= StRd;
          end else begin
            state_q <= StWr;
            rwbar_q <= 1'b0;
            ramin_q <= wr_bg;
          end
        end
        default: begin
          state_q <= StIdle;
          cs_q    <= 1'b0;
          rwbar_q <= 1'b1;
          ramin_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram.ramaddr = addr_q;
  assign ram.ramin   = ramin_q;
  assign ram.rwbar   = rwbar_q;
  assign ram.cs      = cs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign fail_addr   = fail_addr_q;
  assign fail_elem   = fail_elem_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: 64x8 SRAM model with one injectable stuck fault,
// a March C- operation plan built from the algorithm table, table-driven and random runs.
module tb_mbist_march_ctrl;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int NW = 64;
`ifdef MBIST_FAIL_STOP_EN
  localparam bit FailStop = 1'b1;
`else
  localparam bit FailStop = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_bus ();

  mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram       (ram_bus),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  // SRAM model with a stuck fault applied on the read path
  logic [DW-1:0] mem [NW];
  logic          f_en = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_mask = '0;
  logic [DW-1:0] f_val = '0;

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
    if (f_en && a == f_addr) return (v & ~f_mask) | (f_val & f_mask);
    return v;
  endfunction

  always @(posedge clk) begin
    if (ram_bus.cs) begin
      if (ram_bus.rwbar) ram_bus.ramout <= faulty(ram_bus.ramaddr, mem[ram_bus.ramaddr]);
      else mem[ram_bus.ramaddr] <= ram_bus.ramin;
    end
  end

  // Expected per-cycle operation plan
  typedef struct {
    bit            wr;
    bit            cmp;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            elem;
  } cyc_t;

  cyc_t plan[$];

  function automatic logic [DW-1:0] bg_rd(input int e);
    return (e == 2 || e == 4) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [DW-1:0] bg_wr(input int e);
    return (e == 1 || e == 3) ? 8'hFF : 8'h00;
  endfunction

  task automatic build_plan();
    cyc_t c;
    plan.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < NW; i++) begin
        c.elem = e;
        c.addr = AW'((e == 3 || e == 4) ? (NW - 1 - i) : i);
        if (e == 0) begin
          c.wr = 1; c.cmp = 0; c.data = 8'h00; plan.push_back(c);
        end else begin
          c.wr = 0; c.cmp = 0; c.data = 8'h00;      plan.push_back(c);
          c.wr = 0; c.cmp = 1; c.data = bg_rd(e);   plan.push_back(c);
          if (e != 5) begin
            c.wr = 1; c.cmp = 0; c.data = bg_wr(e); plan.push_back(c);
          end
        end
      end
    end
  endtask

  // Walk the plan against an ideal memory seen through the fault to find the first mismatch
  task automatic predict(output int p_done, output bit p_fail, output int p_addr,
                         output int p_elem);
    logic [DW-1:0] m [NW];
    logic [DW-1:0] rd;
    int            p_stop;
    p_fail = 0; p_addr = 0; p_elem = 0; p_stop = 0; rd = '0;
    foreach (m[i]) m[i] = '0;
    for (int i = 0; i < plan.size(); i++) begin
      if (plan[i].wr) m[plan[i].addr] = plan[i].data;
      else if (!plan[i].cmp) rd = faulty(plan[i].addr, m[plan[i].addr]);
      else if (!p_fail && rd != plan[i].data) begin
        p_fail = 1; p_addr = plan[i].addr; p_elem = plan[i].elem; p_stop = i + 1;
      end
    end
    p_done = (FailStop && p_fail) ? p_stop : plan.size();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full run from a start pulse; poke > 0 pulses start again while busy at that cycle
  task automatic run_test(input int poke, input int e_done, input bit e_fail, input int e_addr,
                          input int e_elem);
    int   k;
    cyc_t c;
    logic [31:0] act;
    logic [31:0] exp;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k <= 2000) begin
      if (k - 1 < e_done) begin
        c   = plan[k-1];
        exp = {15'd0, 1'b1, ~c.wr, c.addr, (c.wr ? c.data : 8'h00), 1'b1};
        act = {15'd0, ram_bus.cs, ram_bus.rwbar, ram_bus.ramaddr,
               (c.wr ? ram_bus.ramin : 8'h00), busy};
        chk($sformatf("bus_cycle%0d", k), act, exp);
      end
      start = (k == poke) ? 1'b1 : 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_edge", k - 1, e_done);
    chk("fail", {31'd0, fail}, {31'd0, e_fail});
    chk("fail_addr", {26'd0, fail_addr}, e_fail ? e_addr : 0);
    chk("fail_elem", {29'd0, fail_elem}, e_fail ? e_elem : 0);
    chk("idle_bus", {ram_bus.cs, ram_bus.rwbar, ram_bus.ramin, busy},
        {1'b0, 1'b1, 8'h00, 1'b0});
    repeat (3) @(negedge clk);
    chk("done_hold", {done, ram_bus.cs, busy}, {1'b1, 1'b0, 1'b0});
  endtask

  typedef struct {
    bit            en;
    int            addr;
    logic [DW-1:0] mask;
    logic [DW-1:0] val;
    int            poke;
    bit            e_fail;
    int            e_addr;
    int            e_elem;
    int            e_stop;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int   p_done;
    bit   p_fail;
    int   p_addr;
    int   p_elem;
    int   poke;
    vec_t v;

    build_plan();

    // Reset state
    @(negedge clk);
    chk("rst_outputs", {ram_bus.cs, ram_bus.rwbar, ram_bus.ramaddr, ram_bus.ramin, busy, done,
                        fail, fail_addr, fail_elem},
        {1'b0, 1'b1, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {ram_bus.cs, busy, done}, 3'b000);

    // en, addr, mask, val, poke, fail, fail_addr, fail_elem, CMP cycle of first mismatch
    vecs.push_back('{0,  0, 8'h00, 8'h00, 100, 0,  0, 0,   0});
    vecs.push_back('{1, 37, 8'h08, 8'h08,   0, 1, 37, 1, 177});
    vecs.push_back('{1,  5, 8'hFF, 8'hFF,   0, 1,  5, 1,  81});
    vecs.push_back('{1,  5, 8'hFF, 8'h00,   0, 1,  5, 2, 273});
    vecs.push_back('{1,  0, 8'h80, 8'h00,   0, 1,  0, 2, 258});
    vecs.push_back('{1, 63, 8'h01, 8'h01,   0, 1, 63, 1, 255});
    vecs.push_back('{0,  0, 8'h00, 8'h00,  50, 0,  0, 0,   0});

    foreach (vecs[i]) begin
      v = vecs[i];
      f_en = v.en; f_addr = AW'(v.addr); f_mask = v.mask; f_val = v.val;
      run_test(v.poke, (FailStop && v.e_fail) ? v.e_stop : 960, v.e_fail, v.e_addr, v.e_elem);
    end

    // Reset in the middle of a run
    f_en = 1'b1; f_addr = 6'd37; f_mask = 8'h08; f_val = 8'h08;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {ram_bus.cs, ram_bus.rwbar, ram_bus.ramaddr, ram_bus.ramin, busy, done,
                           fail, fail_addr, fail_elem},
        {1'b0, 1'b1, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", {ram_bus.cs, busy, done}, 3'b000);
    f_en = 1'b0;
    run_test(0, 960, 0, 0, 0);

    // Random single faults checked against the plan-walking model
    for (int r = 0; r < 8; r++) begin
      f_en   = 1'b1;
      f_addr = AW'($urandom_range(0, NW - 1));
      f_val  = DW'($urandom_range(0, 255));
      f_mask = ($urandom_range(0, 1) == 1) ? 8'hFF : DW'(1 << $urandom_range(0, DW - 1));
      predict(p_done, p_fail, p_addr, p_elem);
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, p_done - 1) : 0;
      run_test(poke, p_done, p_fail, p_addr, p_elem);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
